rs_alloc_ctrl: RTL and testbench

Parametrised dispatch-to-reservation-station allocator sitting between the dispatch stage and the RS bank. Classifies each dispatch slot by target RS, tracks a registered free-entry credit per RS, and accepts the longest in-order prefix of the dispatch bundle that fits. It supersedes the fixed 2-wide, stateless request decode by adding credit accounting, partial acceptance and flush recovery.

---
 rtl/rs_alloc_ctrl_pkg.sv | 16 +
 rtl/rs_alloc_ctrl_if.sv | 32 +++
 rtl/rs_credit_cnt.sv | 46 ++++
 rtl/rs_alloc_ctrl.sv | 102 ++++++++++
 tb/tb_rs_alloc_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_alloc_ctrl_pkg.sv
// Shared constants for the dispatch-to-RS allocator: default geometry and RS select codes.
package rs_alloc_ctrl_pkg;

  localparam int DP_WIDTH_DEF = 2;
  localparam int RS_NUM_DEF   = 4;
  localparam int RS_SEL_DEF   = 2;
  localparam int RS_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    RS_ALU  = 2'd0,
    RS_MUL  = 2'd1,
    RS_LDST = 2'd2,
    RS_BR   = 2'd3
  } rs_type_e;

endpackage

// File: rtl/rs_alloc_ctrl_if.sv
// Dispatch/RS-bank signal bundle seen by the allocator; master is the dispatch side.
interface rs_alloc_ctrl_if #(
  parameter int DP_WIDTH = 2,
  parameter int RS_NUM   = 4,
  parameter int RS_SEL   = 2,
  parameter int RS_DEPTH = 8
);
  localparam int CNT_W = $clog2(RS_DEPTH + 1);
  localparam int NUM_W = $clog2(DP_WIDTH + 1);

  logic [DP_WIDTH-1:0]        i_dp_vld;
  logic [DP_WIDTH*RS_SEL-1:0] i_dp_rs_sel;
  logic                       i_stall_ext;
  logic                       i_flush;
  logic [RS_NUM-1:0]          i_rs_free;
  logic [DP_WIDTH-1:0]        o_dp_accept;
  logic [RS_NUM*DP_WIDTH-1:0] o_rs_alloc;
  logic [RS_NUM*NUM_W-1:0]    o_rs_alloc_num;
  logic [RS_NUM*CNT_W-1:0]    o_rs_credit;
  logic [RS_NUM-1:0]          o_stall_rs;

  modport master (
    output i_dp_vld, i_dp_rs_sel, i_stall_ext, i_flush, i_rs_free,
    input  o_dp_accept, o_rs_alloc, o_rs_alloc_num, o_rs_credit, o_stall_rs
  );

  modport slave (
    input  i_dp_vld, i_dp_rs_sel, i_stall_ext, i_flush, i_rs_free,
    output o_dp_accept, o_rs_alloc, o_rs_alloc_num, o_rs_credit, o_stall_rs
  );

endinterface

// File: rtl/rs_credit_cnt.sv
// Free-entry credit counter for one reservation station: flush refills, allocs consume, frees return.
module rs_credit_cnt #(
  parameter int RS_DEPTH = 8,
  parameter int DP_WIDTH = 2
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_flush,
  input  logic [$clog2(DP_WIDTH + 1)-1:0]     i_alloc_num,
  input  logic                                i_free,
  output logic [$clog2(RS_DEPTH + 1)-1:0]     o_credit
);
  localparam int CNT_W = $clog2(RS_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  logic [CNT_W-1:0] credit_q;
  logic [CNT_W-1:0] credit_d;
  logic [SUM_W-1:0] sum_s;

  // Next credit; an illegal free at full depth saturates instead of wrapping.
  always_comb begin
    sum_s = SUM_W'(credit_q) - SUM_W'(i_alloc_num) + SUM_W'(i_free);
    if (i_flush) begin
      credit_d = CNT_W'(RS_DEPTH);
    end else if (sum_s > SUM_W'(RS_DEPTH)) begin
      credit_d = CNT_W'(RS_DEPTH);
    end else begin
      credit_d = sum_s[CNT_W-1:0];
    end
  end

  // Credit register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      credit_q <= CNT_W'(RS_DEPTH);
    end else begin
      credit_q <= credit_d;
    end
  end

  assign o_credit = credit_q;

  a_no_free_when_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_free && !i_flush && (i_alloc_num == '0) && (credit_q == CNT_W'(RS_DEPTH))));

endmodule

// File: rtl/rs_alloc_ctrl.sv
// Dispatch-to-RS allocator: classifies slots, accepts the longest in-order prefix that fits
// the per-RS credits, and attributes the stall to the RS blocking the first rejected slot.
module rs_alloc_ctrl
  import rs_alloc_ctrl_pkg::*;
#(
  parameter int DP_WIDTH = DP_WIDTH_DEF,
  parameter int RS_NUM   = RS_NUM_DEF,
  parameter int RS_SEL   = RS_SEL_DEF,
  parameter int RS_DEPTH = RS_DEPTH_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  rs_alloc_ctrl_if.slave  dp_if
);
  localparam int CNT_W = $clog2(RS_DEPTH + 1);
  localparam int NUM_W = $clog2(DP_WIDTH + 1);

  logic [RS_SEL-1:0]               sel_s     [DP_WIDTH];
  logic [RS_NUM-1:0][DP_WIDTH-1:0] req_s;
  logic [NUM_W-1:0]                cum_s     [RS_NUM][DP_WIDTH];
  logic [CNT_W-1:0]                credit_s  [RS_NUM];
  logic [NUM_W-1:0]                alloc_num_s [RS_NUM];
  logic [DP_WIDTH-1:0]             fits_s;
  logic [DP_WIDTH-1:0]             accept_s;
  logic [RS_NUM-1:0]               stall_rs_s;
  logic                            open_s;
  logic                            found_s;

  // Per-slot selector decode and running per-RS request counts (prefix sums).
  always_comb begin
    req_s = '0;
    cum_s = '{default: '0};
    for (int s = 0; s < DP_WIDTH; s++) begin
      sel_s[s] = dp_if.i_dp_rs_sel[s*RS_SEL +: RS_SEL];
    end
    for (int k = 0; k < RS_NUM; k++) begin
      for (int s = 0; s < DP_WIDTH; s++) begin
        req_s[k][s] = dp_if.i_dp_vld[s] && (sel_s[s] == RS_SEL'(k));
        cum_s[k][s] = ((s == 0) ? NUM_W'(0) : cum_s[k][(s == 0) ? 0 : s - 1])
                      + NUM_W'(req_s[k][s]);
      end
    end
  end

  // Fit test, prefix accept chain and stall attribution for the lowest rejected slot.
  always_comb begin
    open_s     = !dp_if.i_flush && !dp_if.i_stall_ext;
    fits_s     = '0;
    accept_s   = '0;
    stall_rs_s = '0;
    found_s    = 1'b0;
    for (int s = 0; s < DP_WIDTH; s++) begin
      for (int k = 0; k < RS_NUM; k++) begin
        fits_s[s] = fits_s[s] | (open_s && req_s[k][s] &&
                                 (int'(cum_s[k][s]) <= int'(credit_s[k])));
      end
      accept_s[s] = fits_s[s] && ((s == 0) ? 1'b1 : accept_s[(s == 0) ? 0 : s - 1]);
    end
    for (int s = 0; s < DP_WIDTH; s++) begin
      if (!found_s && !accept_s[s]) begin
        found_s = 1'b1;
        for (int k = 0; k < RS_NUM; k++) begin
          stall_rs_s[k] = open_s && req_s[k][s];
        end
      end else begin
        found_s = found_s;
      end
    end
  end

  // Accepted-slot grant matrix and per-RS allocation counts.
  always_comb begin
    dp_if.o_rs_alloc = '0;
    alloc_num_s      = '{default: '0};
    for (int k = 0; k < RS_NUM; k++) begin
      for (int s = 0; s < DP_WIDTH; s++) begin
        dp_if.o_rs_alloc[k*DP_WIDTH + s] = req_s[k][s] && accept_s[s];
        alloc_num_s[k] = alloc_num_s[k] + NUM_W'(req_s[k][s] && accept_s[s]);
      end
    end
  end

  assign dp_if.o_dp_accept = accept_s;
  assign dp_if.o_stall_rs  = stall_rs_s;

  for (genvar k = 0; k < RS_NUM; k++) begin : g_rs
    rs_credit_cnt #(
      .RS_DEPTH (RS_DEPTH),
      .DP_WIDTH (DP_WIDTH)
    ) u_credit (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_flush     (dp_if.i_flush),
      .i_alloc_num (alloc_num_s[k]),
      .i_free      (dp_if.i_rs_free[k]),
      .o_credit    (credit_s[k])
    );
    assign dp_if.o_rs_credit[k*CNT_W +: CNT_W]    = credit_s[k];
    assign dp_if.o_rs_alloc_num[k*NUM_W +: NUM_W] = alloc_num_s[k];
  end

endmodule

// File: tb/tb_rs_alloc_ctrl.sv
// Directed bench for rs_alloc_ctrl: credit drain, partial acceptance, free latency, flush, stall.
module tb_rs_alloc_ctrl;
  import rs_alloc_ctrl_pkg::*;

  localparam int DPW   = 2;
  localparam int RSN   = 4;
  localparam int RSS   = 2;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NUM_W = $clog2(DPW + 1);

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  rs_alloc_ctrl_if #(.DP_WIDTH(DPW), .RS_NUM(RSN), .RS_SEL(RSS), .RS_DEPTH(DEPTH)) dp_if ();

  rs_alloc_ctrl #(.DP_WIDTH(DPW), .RS_NUM(RSN), .RS_SEL(RSS), .RS_DEPTH(DEPTH)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .dp_if   (dp_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] cred(input int k);
    return dp_if.o_rs_credit[k*CNT_W +: CNT_W];
  endfunction

  function automatic logic [NUM_W-1:0] anum(input int k);
    return dp_if.o_rs_alloc_num[k*NUM_W +: NUM_W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] vld, input logic [1:0] s0, input logic [1:0] s1,
                       input logic stall, input logic flush, input logic [3:0] free);
    dp_if.i_dp_vld    = vld;
    dp_if.i_dp_rs_sel = {s1, s0};
    dp_if.i_stall_ext = stall;
    dp_if.i_flush     = flush;
    dp_if.i_rs_free   = free;
  endtask

  task automatic do_reset();
    drive(2'b00, RS_ALU, RS_ALU, 1'b0, 1'b0, 4'b0000);
    #2;
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++;
    if (dp_if.o_dp_accept !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_accept: got %b want 00", dp_if.o_dp_accept);
    end
    for (int k = 0; k < RSN; k++) begin
      vectors++;
      if (cred(k) !== 4'd8) begin
        miscompares++;
        $display("FAIL reset_credit[%0d]: got %0d want 8", k, cred(k));
      end
    end
    vectors++;
    if ({dp_if.o_rs_alloc, dp_if.o_stall_rs, dp_if.o_rs_alloc_num} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_idle_outputs: alloc %h stall %b num %h want zero",
               dp_if.o_rs_alloc, dp_if.o_stall_rs, dp_if.o_rs_alloc_num);
    end
  endtask

  task automatic test_invalid_gap();
    tick();
    drive(2'b10, RS_ALU, RS_ALU, 1'b0, 1'b0, 4'b0000);
    #1;
    vectors++;
    if ({dp_if.o_dp_accept, dp_if.o_stall_rs, dp_if.o_rs_alloc} !== 14'h0) begin
      miscompares++;
      $display("FAIL invalid_gap: accept %b stall %b alloc %h want all zero",
               dp_if.o_dp_accept, dp_if.o_stall_rs, dp_if.o_rs_alloc);
    end
  endtask

  task automatic test_alu_fill();
    logic [1:0] exp_acc;
    logic [3:0] exp_cred;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      drive(2'b11, RS_ALU, RS_ALU, 1'b0, 1'b0, 4'b0000);
      #1;
      exp_acc  = (i < 4) ? 2'b11 : 2'b00;
      exp_cred = 4'(8 - 2 * i);
      vectors++;
      if (dp_if.o_dp_accept !== exp_acc) begin
        miscompares++;
        $display("FAIL fill_accept[%0d]: got %b want %b", i, dp_if.o_dp_accept, exp_acc);
      end
      vectors++;
      if (cred(0) !== exp_cred) begin
        miscompares++;
        $display("FAIL fill_credit[%0d]: got %0d want %0d", i, cred(0), exp_cred);
      end
      if (i == 0) begin
        vectors++;
        if (anum(0) !== 2'd2 || dp_if.o_rs_alloc !== 8'h03) begin
          miscompares++;
          $display("FAIL fill_alloc: num %0d alloc %h want 2 / 03", anum(0), dp_if.o_rs_alloc);
        end
      end
      if (i == 4) begin
        vectors++;
        if (dp_if.o_stall_rs !== 4'b0001 || dp_if.o_rs_alloc !== 8'h00) begin
          miscompares++;
          $display("FAIL fill_stall: stall %b alloc %h want 0001 / 00",
                   dp_if.o_stall_rs, dp_if.o_rs_alloc);
        end
      end
    end
    tick();
    drive(2'b00, RS_ALU, RS_ALU, 1'b0, 1'b0, 4'b0000);
    #1;
    vectors++;
    if (cred(0) !== 4'd0) begin
      miscompares++;
      $display("FAIL fill_empty_hold: got %0d want 0", cred(0));
    end
  endtask

  task automatic test_partial();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(2'b11, RS_ALU, RS_ALU, 1'b0, 1'b0, 4'b0000);
    end
    tick();
    drive(2'b01, RS_ALU, RS_ALU, 1'b0, 1'b0, 4'b0000);
    tick();
    drive(2'b11, RS_ALU, RS_ALU, 1'b0, 1'b0, 4'b0000);
    #1;
    vectors++;
    if (cred(0) !== 4'd1 || dp_if.o_dp_accept !== 2'b01 || anum(0) !== 2'd1
        || dp_if.o_stall_rs !== 4'b0001) begin
      miscompares++;
      $display("FAIL partial_alu1: cred %0d accept %b num %0d stall %b want 1 01 1 0001",
               cred(0), dp_if.o_dp_accept, anum(0), dp_if.o_stall_rs);
    end
    tick();
    drive(2'b11, RS_MUL, RS_ALU, 1'b0, 1'b0, 4'b0000);
    #1;
    vectors++;
    if (cred(0) !== 4'd0 || dp_if.o_dp_accept !== 2'b01 || dp_if.o_rs_alloc !== 8'h04
        || dp_if.o_stall_rs !== 4'b0001) begin
      miscompares++;
      $display("FAIL partial_mul_alu: cred %0d accept %b alloc %h stall %b want 0 01 04 0001",
               cred(0), dp_if.o_dp_accept, dp_if.o_rs_alloc, dp_if.o_stall_rs);
    end
    tick();
    drive(2'b11, RS_ALU, RS_MUL, 1'b0, 1'b0, 4'b0000);
    #1;
    vectors++;
    if (cred(1) !== 4'd7 || dp_if.o_dp_accept !== 2'b00 || dp_if.o_stall_rs !== 4'b0001) begin
      miscompares++;
      $display("FAIL partial_alu_mul: mulcred %0d accept %b stall %b want 7 00 0001",
               cred(1), dp_if.o_dp_accept, dp_if.o_stall_rs);
    end
  endtask

  task automatic test_free_latency();
    tick();
    drive(2'b01, RS_ALU, RS_ALU, 1'b0, 1'b0, 4'b0001);
    #1;
    vectors++;
    if (cred(0) !== 4'd0 || dp_if.o_dp_accept !== 2'b00) begin
      miscompares++;
      $display("FAIL free_same_cycle: cred %0d accept %b want 0 00", cred(0), dp_if.o_dp_accept);
    end
    tick();
    #1;
    vectors++;
    if (cred(0) !== 4'd1 || dp_if.o_dp_accept !== 2'b01) begin
      miscompares++;
      $display("FAIL free_next_cycle: cred %0d accept %b want 1 01", cred(0), dp_if.o_dp_accept);
    end
    tick();
    drive(2'b00, RS_ALU, RS_ALU, 1'b0, 1'b0, 4'b0000);
    #1;
    vectors++;
    if (cred(0) !== 4'd1) begin
      miscompares++;
      $display("FAIL free_alloc_balance: got %0d want 1", cred(0));
    end
  endtask

  task automatic test_flush();
    do_reset();
    tick(); drive(2'b11, RS_ALU, RS_ALU, 1'b0, 1'b0, 4'b0000);
    tick(); drive(2'b11, RS_ALU, RS_ALU, 1'b0, 1'b0, 4'b0000);
    tick(); drive(2'b11, RS_ALU, RS_MUL, 1'b0, 1'b0, 4'b0000);
    tick(); drive(2'b11, RS_MUL, RS_MUL, 1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      tick(); drive(2'b11, RS_LDST, RS_LDST, 1'b0, 1'b0, 4'b0000);
    end
    tick();
    drive(2'b00, RS_ALU, RS_ALU, 1'b0, 1'b0, 4'b0000);
    #1;
    vectors++;
    if ({cred(3), cred(2), cred(1), cred(0)} !== 16'h8053) begin
      miscompares++;
      $display("FAIL flush_setup: credits %h want 8053", {cred(3), cred(2), cred(1), cred(0)});
    end
    drive(2'b11, RS_ALU, RS_MUL, 1'b0, 1'b1, 4'b1111);
    #1;
    vectors++;
    if (dp_if.o_dp_accept !== 2'b00 || dp_if.o_stall_rs !== 4'b0000 || dp_if.o_rs_alloc !== 8'h00) begin
      miscompares++;
      $display("FAIL flush_accept: accept %b stall %b alloc %h want 00 0000 00",
               dp_if.o_dp_accept, dp_if.o_stall_rs, dp_if.o_rs_alloc);
    end
    tick();
    drive(2'b00, RS_ALU, RS_ALU, 1'b0, 1'b0, 4'b0000);
    #1;
    vectors++;
    if ({cred(3), cred(2), cred(1), cred(0)} !== 16'h8888) begin
      miscompares++;
      $display("FAIL flush_refill: credits %h want 8888", {cred(3), cred(2), cred(1), cred(0)});
    end
  endtask

  task automatic test_stall_ext();
    do_reset();
    tick(); drive(2'b11, RS_MUL, RS_MUL, 1'b0, 1'b0, 4'b0000);
    tick(); drive(2'b11, RS_MUL, RS_MUL, 1'b0, 1'b0, 4'b0000);
    tick();
    drive(2'b11, RS_ALU, RS_MUL, 1'b1, 1'b0, 4'b0010);
    #1;
    vectors++;
    if (cred(1) !== 4'd4 || dp_if.o_dp_accept !== 2'b00 || dp_if.o_stall_rs !== 4'b0000) begin
      miscompares++;
      $display("FAIL stall_ext: mulcred %0d accept %b stall %b want 4 00 0000",
               cred(1), dp_if.o_dp_accept, dp_if.o_stall_rs);
    end
    tick();
    drive(2'b00, RS_ALU, RS_ALU, 1'b0, 1'b0, 4'b0000);
    #1;
    vectors++;
    if (cred(1) !== 4'd5 || cred(0) !== 4'd8) begin
      miscompares++;
      $display("FAIL stall_ext_free: mul %0d alu %0d want 5 8", cred(1), cred(0));
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b1;
    test_reset();
    test_invalid_gap();
    test_alu_fill();
    test_partial();
    test_free_latency();
    test_flush();
    test_stall_ext();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
